// File: rtl/line_buffer_window.sv
// rtl/line_buffer_window.sv - 3x3 sliding pixel window over a raster stream using two line memories
//
// Purpose: turns a raster-order 8-bit pixel stream into 3x3 neighbourhoods for
// a convolution stage. Output appears one cycle after the pixel that completes
// a window. No window is flagged valid until three rows have been seen, and no
// window is flagged valid across a row boundary.
//
// Optional feature: define LBW_SOF_EN to add the i_sof start-of-frame input.
//
// Ports:
//   i_clk              clock, rising edge
//   i_rst              synchronous active-high reset
//   i_pixel            8-bit grey pixel, raster order
//   i_pixel_valid      pixel accepted on every clock with this high
//   i_sof              start of frame (LBW_SOF_EN builds only)
//   o_pixel_data       3x3 window, byte k = 3*r + c at [8k+7:8k]
//                      (r=0 oldest row, c=0 leftmost column)
//   o_pixel_data_valid one-cycle qualifier for o_pixel_data

module line_buffer_window #(
    parameter int IMG_WIDTH = 512
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_pixel,
    input  logic        i_pixel_valid,
`ifdef LBW_SOF_EN
    input  logic        i_sof,
`endif
    output logic [71:0] o_pixel_data,
    output logic        o_pixel_data_valid
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);

    typedef enum logic {FILL, RUN} state_t;

    logic [XW-1:0] x_q, x_d, x_cur;
    logic [1:0]    y_q, y_d, y_cur;
    state_t        state_q, state_d, state_cur;
    logic [71:0]   win_q, win_d;
    logic          valid_q, valid_d;
    logic          sof_hit;
    logic [7:0]    l1_rd, l2_rd;

    // Line memories are deliberately not reset: FILL gating keeps stale
    // contents from ever reaching a valid window.
    logic [7:0] line1_mem [IMG_WIDTH];
    logic [7:0] line2_mem [IMG_WIDTH];

`ifdef LBW_SOF_EN
    assign sof_hit = i_sof & i_pixel_valid;
`else
    assign sof_hit = 1'b0;
`endif

    // A start-of-frame pixel is handled as if the position were already (0,0).
    assign x_cur     = sof_hit ? '0   : x_q;
    assign y_cur     = sof_hit ? 2'd0 : y_q;
    assign state_cur = sof_hit ? FILL : state_q;

    assign l1_rd = line1_mem[x_cur];
    assign l2_rd = line2_mem[x_cur];

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        state_d = state_q;
        win_d   = win_q;
        valid_d = 1'b0;
        if (i_rst) begin
            x_d     = '0;
            y_d     = 2'd0;
            state_d = FILL;
            win_d   = '0;
        end else if (i_pixel_valid) begin
            // Columns 0 and 1 would mix the previous row into the window.
            valid_d = (state_cur == RUN) && (x_cur >= XW'(2));
            if (x_cur == X_LAST) begin
                x_d = '0;
                y_d = (y_cur == 2'd2) ? y_cur : y_cur + 2'd1;
            end else begin
                x_d = x_cur + XW'(1);
                y_d = y_cur;
            end
            state_d = (y_d == 2'd2) ? RUN : FILL;
            // Each row shifts one byte toward column 0; new column enters at c=2.
            win_d = {i_pixel, win_q[71:56],
                     l1_rd,   win_q[47:32],
                     l2_rd,   win_q[23:8]};
        end
    end

    always_ff @(posedge i_clk) begin
        x_q     <= x_d;
        y_q     <= y_d;
        state_q <= state_d;
        win_q   <= win_d;
        valid_q <= valid_d;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && i_pixel_valid) begin
            line2_mem[x_cur] <= l1_rd;
            line1_mem[x_cur] <= i_pixel;
        end
    end

    assign o_pixel_data       = win_q;
    assign o_pixel_data_valid = valid_q;

endmodule

// File: tb/tb_line_buffer_window.sv
// tb/tb_line_buffer_window.sv - self-checking bench for line_buffer_window at IMG_WIDTH=4

module tb_line_buffer_window;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_pixel = 8'd0;
    logic        i_pixel_valid = 1'b0;
`ifdef LBW_SOF_EN
    logic        i_sof = 1'b0;
`endif
    logic [71:0] o_pixel_data;
    logic        o_pixel_data_valid;

    line_buffer_window #(.IMG_WIDTH(4)) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_pixel            (i_pixel),
        .i_pixel_valid      (i_pixel_valid),
`ifdef LBW_SOF_EN
        .i_sof              (i_sof),
`endif
        .o_pixel_data       (o_pixel_data),
        .o_pixel_data_valid (o_pixel_data_valid)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [7:0]  pix;
        logic        exp_vld;
        logic        chk_data;
        logic [71:0] exp_data;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic logic [71:0] w9(input int b0, input int b1, input int b2,
                                       input int b3, input int b4, input int b5,
                                       input int b6, input int b7, input int b8);
        return {8'(b8), 8'(b7), 8'(b6), 8'(b5), 8'(b4), 8'(b3), 8'(b2), 8'(b1), 8'(b0)};
    endfunction

    task automatic add(input logic r, input logic v, input int p,
                       input logic ev, input logic cd, input logic [71:0] ed);
        vec_t e;
        e.rst = r; e.vld = v; e.pix = 8'(p);
        e.exp_vld = ev; e.chk_data = cd; e.exp_data = ed;
        vecs.push_back(e);
    endtask

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // One clock: drive, let the edge pass, sample 1 ns later.
    task automatic cyc(input logic r, input logic v, input int p);
        i_rst = r; i_pixel_valid = v; i_pixel = 8'(p);
        @(posedge i_clk);
        #1;
    endtask

    logic [71:0] ref_win [4];
    int          ref_pix [4];

    initial begin
        int k;
        ref_pix = '{10, 11, 14, 15};
        ref_win[0] = w9(0, 1, 2, 4, 5, 6, 8, 9, 10);
        ref_win[1] = w9(1, 2, 3, 5, 6, 7, 9, 10, 11);
        ref_win[2] = w9(4, 5, 6, 8, 9, 10, 12, 13, 14);
        ref_win[3] = w9(5, 6, 7, 9, 10, 11, 13, 14, 15);

        // Frame of 16 back-to-back pixels, then a hold cycle.
        add(1, 0, 0, 0, 1, '0);
        k = 0;
        for (int p = 0; p < 16; p++) begin
            if (k < 4 && ref_pix[k] == p) begin
                add(0, 1, p, 1, 1, ref_win[k]);
                k++;
            end else begin
                add(0, 1, p, 0, 0, '0);
            end
        end
        add(0, 0, 0, 0, 1, ref_win[3]);
        // Mid-frame reset after pixel 9 (state RUN), with a pixel that must be dropped.
        add(1, 0, 0, 0, 1, '0);
        for (int p = 0; p < 10; p++) add(0, 1, p, 0, 0, '0);
        add(1, 1, 99, 0, 1, '0);
        for (int p = 100; p < 110; p++) add(0, 1, p, 0, 0, '0);
        add(0, 1, 110, 1, 1, w9(100, 101, 102, 104, 105, 106, 108, 109, 110));
        add(0, 1, 111, 1, 1, w9(101, 102, 103, 105, 106, 107, 109, 110, 111));

        // Reset state and idle behaviour.
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("reset_valid", {71'd0, o_pixel_data_valid}, 72'd0);
        chk("reset_data", o_pixel_data, 72'd0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0);
            chk($sformatf("idle_valid_%0d", i), {71'd0, o_pixel_data_valid}, 72'd0);
            chk($sformatf("idle_data_%0d", i), o_pixel_data, 72'd0);
        end

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst, vecs[i].vld, int'(vecs[i].pix));
            chk($sformatf("vec%0d_valid", i), {71'd0, o_pixel_data_valid}, {71'd0, vecs[i].exp_vld});
            if (vecs[i].chk_data)
                chk($sformatf("vec%0d_data", i), o_pixel_data, vecs[i].exp_data);
        end

        // Same frame with i_pixel_valid alternating 1/0.
        cyc(1, 0, 0);
        k = 0;
        for (int p = 0; p < 16; p++) begin
            logic hit;
            hit = (k < 4 && ref_pix[k] == p);
            cyc(0, 1, p);
            chk($sformatf("alt_p%0d_valid", p), {71'd0, o_pixel_data_valid}, {71'd0, hit});
            if (hit) chk($sformatf("alt_p%0d_data", p), o_pixel_data, ref_win[k]);
            cyc(0, 0, 0);
            chk($sformatf("alt_gap%0d_valid", p), {71'd0, o_pixel_data_valid}, 72'd0);
            if (hit) begin
                chk($sformatf("alt_gap%0d_hold", p), o_pixel_data, ref_win[k]);
                k++;
            end
        end

`ifdef LBW_SOF_EN
        // Six pixels, then SOF restarts the frame at pixel 50.
        cyc(1, 0, 0);
        for (int p = 1; p <= 6; p++) begin
            cyc(0, 1, p);
            chk($sformatf("sof_pre%0d_valid", p), {71'd0, o_pixel_data_valid}, 72'd0);
        end
        i_sof = 1'b1;
        cyc(0, 1, 50);
        i_sof = 1'b0;
        chk("sof_p50_valid", {71'd0, o_pixel_data_valid}, 72'd0);
        for (int p = 51; p <= 61; p++) begin
            cyc(0, 1, p);
            chk($sformatf("sof_p%0d_valid", p), {71'd0, o_pixel_data_valid},
                {71'd0, (p == 60 || p == 61)});
            if (p == 60) chk("sof_p60_data", o_pixel_data, w9(50, 51, 52, 54, 55, 56, 58, 59, 60));
            if (p == 61) chk("sof_p61_data", o_pixel_data, w9(51, 52, 53, 55, 56, 57, 59, 60, 61));
        end
        // SOF without a pixel is ignored: the next pixel continues row 2 at x=0.
        i_sof = 1'b1;
        cyc(0, 0, 0);
        i_sof = 1'b0;
        cyc(0, 1, 62);
        cyc(0, 1, 63);
        cyc(0, 1, 64);
        chk("sof_ignored_valid", {71'd0, o_pixel_data_valid}, 72'd1);
        chk("sof_ignored_data", o_pixel_data, w9(54, 55, 56, 58, 59, 60, 62, 63, 64));
`endif

        cyc(0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/line_buffer_window.md
LINE_BUFFER_WINDOW -- requirements
Module: line_buffer_window

Interface
- REQ-001: Parameter IMG_WIDTH, default 512, pixels per image row; legal range 3..4096.
- REQ-002: i_clk  input  1  sole clock; all logic on rising edge.
- REQ-003: i_rst  input  1  reset, synchronous, active-high.
- REQ-004: i_pixel  input  8  unsigned grey pixel, raster order.
- REQ-005: i_pixel_valid  input  1  i_pixel accepted on every clock with this high; no backpressure.
- REQ-006: o_pixel_data  output  72  3x3 window; byte k at bits [8k+7:8k], k = 3*r + c.
  - r=0 is the oldest row, r=2 the current row.
  - c=0 is the leftmost (oldest) column.
- REQ-007: o_pixel_data_valid  output  1  single-cycle qualifier for o_pixel_data; direct feed to the convolution stage's pixel input pair.
- REQ-008: i_sof  input  1  start of frame; present only when LBW_SOF_EN is defined.

Function
- REQ-009: Position tracking.
  - Column counter x counts 0..IMG_WIDTH-1 and advances only on accepted pixels.
  - x wraps to 0 after IMG_WIDTH-1 and then increments row count y.
  - y saturates at 2; state FILL while y<2, RUN once y=2, no return to FILL except by reset or SOF.
- REQ-010: Line storage.
  - Two line memories, IMG_WIDTH x 8 each, addressed by x.
  - On an accepted pixel: LINE2[x] <= LINE1[x], then LINE1[x] <= i_pixel, in the same cycle.
- REQ-011: Window register.
  - A 3x3 shift register shifts one column left per accepted pixel.
  - New right column is {LINE2[x], LINE1[x], i_pixel} for r=0,1,2.
  - The window holds when i_pixel_valid is low.
- REQ-012: Latency is 1 cycle.
  - For a pixel accepted at (y,x) in cycle t: o_pixel_data_valid=1 in cycle t+1 iff state is RUN (or becomes RUN with this pixel) and x>=2.
  - o_pixel_data in cycle t+1 = pixels rows y-2..y, cols x-2..x.
- REQ-013: o_pixel_data_valid=0 in any cycle following a cycle with i_pixel_valid=0.
  - o_pixel_data holds its last value in that case.
- REQ-014: No windows straddle rows.
  - Columns 0 and 1 of every row produce no valid output.
  - Each row in RUN yields exactly IMG_WIDTH-2 windows.
- REQ-015: Reset mid-operation discards position state; the next accepted pixel is (0,0).
- REQ-016: Line-memory contents are not reset; FILL gating guarantees stale data is never flagged valid.

Reset
- REQ-017: On i_rst=1 at a clock edge:
  - x, y set to 0, state set to FILL.
  - o_pixel_data_valid set to 0, o_pixel_data set to 72'h0, window register cleared.
- REQ-018: i_rst has priority over i_pixel_valid and i_sof; a pixel presented in a reset cycle is dropped.

Configuration
- REQ-019: Macro LBW_SOF_EN.
  - When defined: i_sof exists. i_sof=1 with i_pixel_valid=1 treats that pixel as (0,0), forces FILL, and suppresses output for that pixel.
  - i_sof with i_pixel_valid=0 is ignored.
  - When undefined: no i_sof port; frames are delimited only by reset.

Verification
- REQ-020: IMG_WIDTH=4, pixels 0..15 back-to-back -> exactly 4 valid pulses, after pixels 10, 11, 14, 15.
  - First window bytes k0..k8 = 0,1,2,4,5,6,8,9,10.
  - Window after pixel 14 = 4,5,6,8,9,10,12,13,14.
- REQ-021: Same stream with i_pixel_valid alternating 1/0 -> identical 4 windows in the same order.
  - Valid pulses are spaced 2 cycles apart where consecutive; valid is never high twice in a row.
- REQ-022: i_rst pulsed for 1 cycle after pixel 9, then pixels 100..111 -> no valid before the 11th new pixel.
  - First window = 100,101,102,104,105,106,108,109,110.
- REQ-023: Out of reset, no stimulus -> o_pixel_data=0 and o_pixel_data_valid=0 for 20 cycles.
  - Same values are required on the cycle after i_rst asserts during RUN.
- REQ-024: LBW_SOF_EN defined, IMG_WIDTH=4: 6 pixels, then i_sof with pixel 50 followed by 51..61 -> first valid after pixel 60.
  - First window = 50,51,52,54,55,56,58,59,60.
  - Macro undefined -> elaboration shows no i_sof port.
